rr_arbiter_8: RTL
=================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter QUANTUM, default 4, gives the maximum consecutive grant cycles per owner while other requests are pending; legal range 1..16.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  arbiter enable; when low, no grant is issued or held.
REQ-005 req  input  8  request vector; bit k belongs to requester k.
REQ-006 gnt  output  8  one-hot grant, registered; all zero when no owner.
REQ-007 gnt_idx  output  3  binary index of the current owner; 0 when no owner.
REQ-008 gnt_valid  output  1  high when gnt has exactly one bit set.

Function
REQ-009 The block SHALL hold state IDLE (no owner) or GRANT (owner = gnt_idx), a 3-bit priority pointer ptr and a 4-bit hold counter cnt.
REQ-010 gnt SHALL always equal the 3-to-8 decode of gnt_idx gated by gnt_valid; no other gnt pattern is legal.
REQ-011 Winner search SHALL be circular: the first set bit of the masked request vector at ptr, ptr+1, ..., ptr+7 (mod 8).
REQ-012 IDLE, en=1, any req bit set: the block SHALL enter GRANT on the next edge with the search winner, cnt=0; latency req-to-gnt = 1 cycle.
REQ-013 IDLE, req=0 or en=0: the block SHALL stay IDLE; ptr unchanged.
REQ-014 GRANT, en=1, req[gnt_idx]=1, and (cnt<QUANTUM-1 or no other req bit set): the block SHALL hold the owner; cnt increments, saturating at QUANTUM-1.
REQ-015 GRANT, req[gnt_idx]=0: the block SHALL release at the next edge.
REQ-016 GRANT, cnt=QUANTUM-1, another req bit set: the block SHALL release at the next edge (forced rotation).
REQ-017 On release, ptr SHALL become gnt_idx+1 mod 8 (7 wraps to 0); the search in the same cycle SHALL use that value and exclude the releasing owner.
REQ-018 On release with a search winner, the block SHALL grant the winner on the same edge with cnt=0 (no idle bubble); with no winner it SHALL enter IDLE.
REQ-019 GRANT, en=0: the block SHALL enter IDLE at the next edge, gnt=0, ptr <= gnt_idx+1 mod 8; en has priority over all hold and release rules.
REQ-020 QUANTUM=1: every grant SHALL last exactly 1 cycle whenever another request is pending.
REQ-021 Requests changing in the release cycle SHALL be evaluated from their values sampled at that edge only; no combinational path from req to gnt.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, ptr=0, cnt=0, gnt=8'h00, gnt_idx=0, gnt_valid=0, overriding en and req.
REQ-023 Reset asserted during GRANT SHALL drop the grant at that edge; the first post-reset grant uses ptr=0.

Verification
REQ-024 Reset, then req=8'h01 with en=1 -> one cycle later gnt=8'h01, gnt_idx=0, gnt_valid=1; held while req[0] stays high and req has no other bit set.
REQ-025 QUANTUM=4, req=8'h81 held constant from IDLE, ptr=0 -> gnt alternates: 8'h01 for 4 cycles, 8'h80 for 4 cycles, repeating, with no zero cycle between owners.
REQ-026 Owner 3 drops req while req=8'h22 -> next edge gnt=8'h20 (ptr=4, search from 4 finds 5), cnt=0.
REQ-027 Owner 7 releases with req=8'h04 -> ptr wraps to 0, gnt=8'h04 on the next edge.
REQ-028 en deasserted mid-grant with owner 2 -> next edge gnt=8'h00, gnt_valid=0; en reasserted with req=8'hFF -> gnt=8'h08.
REQ-029 rst pulsed one cycle during GRANT of owner 5 with req=8'hFF -> gnt=8'h00 at the reset edge, then gnt=8'h01 one cycle after rst drops.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-requester round-robin arbiter with a per-owner hold
// quantum. The grant outputs are decoded only from registered state, so
// there is no combinational path from req or en to gnt.
//
// Request/grant protocol: requester k raises req[k] and keeps it high for as
// long as it wants the resource. It owns the resource in every cycle where
// gnt[k] is high. It gives up ownership by dropping req[k]; the release takes
// effect at the next rising edge. While other requests are pending, an owner
// keeps the grant for at most QUANTUM consecutive cycles.
module rr_arbiter_8 #(
    parameter int unsigned QUANTUM = 4  // legal range 1..16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [3:0] CNT_MAX  = 4'(QUANTUM - 1);

    // The complete arbiter state is kept in one struct so it can be probed
    // as a single unit (state, owner, priority pointer, hold count).
    typedef struct packed {
        logic [0:0] state;
        logic [2:0] owner;
        logic [2:0] ptr;
        logic [3:0] cnt;
    } arb_state_t;

    arb_state_t cur;
    arb_state_t nxt;

    logic [7:0] owner_bit;
    logic [7:0] req_others;
    logic       others_pending;
    logic [2:0] rel_ptr;
    logic [3:0] idle_hit;
    logic [3:0] rel_hit;

    // Circular first-one search over vec, starting at position start.
    // Returns {found, index}.
    function automatic logic [3:0] search(input logic [2:0] start,
                                          input logic [7:0] vec);
        logic [3:0] r;
        logic [2:0] k;
        r = 4'b0000;
        // Walk from the farthest position back to start, so the closest hit
        // is the one left in r.
        for (int i = 7; i >= 0; i--) begin
            k = start + 3'(i);
            if (vec[k]) begin
                r = {1'b1, k};
            end
        end
        return r;
    endfunction

    // Decode the search inputs and the two candidate winners.
    always_comb begin
        owner_bit      = 8'b0000_0001 << cur.owner;
        req_others     = req & ~owner_bit;
        others_pending = |req_others;
        rel_ptr        = cur.owner + 3'd1;
        idle_hit       = search(cur.ptr, req);
        rel_hit        = search(rel_ptr, req_others);
    end

    // Next-state rules. en low dominates every hold and release rule.
    always_comb begin
        nxt = cur;
        case (cur.state)
            ST_IDLE: begin
                if (en && idle_hit[3]) begin
                    nxt.state = ST_GRANT;
                    nxt.owner = idle_hit[2:0];
                    nxt.cnt   = 4'd0;
                end
            end
            ST_GRANT: begin
                if (!en) begin
                    nxt.state = ST_IDLE;
                    nxt.owner = 3'd0;
                    nxt.ptr   = rel_ptr;
                    nxt.cnt   = 4'd0;
                end else if (req[cur.owner] &&
                             ((cur.cnt != CNT_MAX) || !others_pending)) begin
                    // Hold: the count saturates so a lone owner can keep the
                    // grant indefinitely.
                    if (cur.cnt != CNT_MAX) begin
                        nxt.cnt = cur.cnt + 4'd1;
                    end
                end else begin
                    // Release, either voluntary or forced by the quantum.
                    // The next owner is granted on the same edge, so no idle
                    // cycle appears between owners.
                    nxt.ptr = rel_ptr;
                    nxt.cnt = 4'd0;
                    if (rel_hit[3]) begin
                        nxt.owner = rel_hit[2:0];
                    end else begin
                        nxt.state = ST_IDLE;
                        nxt.owner = 3'd0;
                    end
                end
            end
            default: begin
                nxt = '0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        gnt_valid = (cur.state == ST_GRANT);
        gnt_idx   = cur.owner;
        gnt       = gnt_valid ? (8'b0000_0001 << cur.owner) : 8'b0000_0000;
    end

endmodule
